// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and the data
// (load/store) stage. One transaction is in flight at a time. Data wins ties,
// except that fetch is forced through after MAX_IWAIT consecutive losses.
// Read data and per-port stall flags go back to the hazard unit.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_IWAIT = 4
) (
    input  logic              clk,
    input  logic              rst,        // active-low, asynchronous
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              stall_f,
    // data port
    input  logic              d_req,
    input  logic [1:0]        d_we,
    input  logic [2:0]        d_re,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              stall_m,
    // memory side
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_we,
    output logic [2:0]        mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(MAX_IWAIT + 1);
    localparam logic [CNT_W-1:0] IWAIT_MAX = CNT_W'(MAX_IWAIT);
    localparam logic [2:0] RE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner_d;
    logic [CNT_W-1:0]  r_iwait;
    logic              w_grant_i;
    logic              w_grant_d;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_mem_we;
    logic [2:0]        r_mem_re;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Arbitration and next-state: grants happen only in IDLE, so a requester
    // still holding req through its DONE cycle is never granted twice.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && i_req) begin
                    if (r_iwait == IWAIT_MAX) w_grant_i = 1'b1;
                    else                      w_grant_d = 1'b1;
                end else if (d_req) begin
                    w_grant_d = 1'b1;
                end else if (i_req) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_i)      w_state_nxt = BUSY_I;
                else if (w_grant_d) w_state_nxt = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fetch starvation counter: counts contested data wins, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iwait <= '0;
        end else if (w_grant_i) begin
            r_iwait <= '0;
        end else if (w_grant_d && i_req && (r_iwait != IWAIT_MAX)) begin
            r_iwait <= r_iwait + CNT_W'(1);
        end
    end

    // Latch the granted port's request onto the memory bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_d   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= '0;
            r_mem_re    <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_d) begin
            r_owner_d   <= 1'b1;
            r_mem_addr  <= d_addr;
            r_mem_we    <= d_we;
            r_mem_re    <= d_re;
            r_mem_wdata <= d_wdata;
        end else if (w_grant_i) begin
            r_owner_d   <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_we    <= 2'b00;
            r_mem_re    <= RE_WORD;
            r_mem_wdata <= '0;
        end
    end

    // Capture memory read data for the owner on ack (stores included)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (mem_ack) begin
            if (r_state == BUSY_I) r_i_rdata <= mem_rdata;
            if (r_state == BUSY_D) r_d_rdata <= mem_rdata;
        end
    end

    assign mem_req   = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_wdata = r_mem_wdata;

    assign i_rvalid  = (r_state == DONE) && !r_owner_d;
    assign d_rvalid  = (r_state == DONE) &&  r_owner_d;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

    // Stalls are forced low while reset is asserted
    assign stall_f   = rst & i_req & ~i_rvalid;
    assign stall_m   = rst & d_req & ~d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: scoreboard of expected grants/completions,
// a simple memory responder with programmable ack delay, directed scenarios.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        stall_f;
    logic        d_req;
    logic [1:0]  d_we;
    logic [2:0]  d_re;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        stall_m;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_we;
    logic [2:0]  mem_re;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_IWAIT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .stall_f(stall_f),
        .d_req(d_req), .d_we(d_we), .d_re(d_re), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .stall_m(stall_m),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [1:0]  we;
        logic [2:0]  re;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic void push_i(input logic [31:0] a);
        exp_t e;
        e.is_d = 1'b0; e.addr = a; e.we = 2'b00; e.re = 3'b010;
        e.wdata = 32'h0; e.rdata = mem_val(a);
        sb_q.push_back(e);
    endfunction

    function automatic void push_d(input logic [31:0] a, input logic [1:0] we,
                                   input logic [2:0] re, input logic [31:0] wd);
        exp_t e;
        e.is_d = 1'b1; e.addr = a; e.we = we; e.re = re;
        e.wdata = wd; e.rdata = mem_val(a);
        sb_q.push_back(e);
    endfunction

    // cycle counter
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory responder: ack after ack_k cycles of mem_req, or constantly
    int   ack_k      = 0;
    bit   ack_always = 1'b0;
    int   rcnt       = 0;
    logic was_req    = 1'b0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                rcnt      = was_req ? rcnt + 1 : 0;
                mem_ack   = ack_always || (rcnt == ack_k);
                mem_rdata = mem_val(mem_addr);
            end else begin
                rcnt      = 0;
                mem_ack   = ack_always;
                mem_rdata = 32'hBAD0_0BAD;
            end
            was_req = mem_req;
        end
    end

    // monitor: check grants against queue head, pop on completion
    bit   sb_en       = 1'b1;
    int   grant_cnt   = 0;
    int   last_rv_cyc = -100;
    int   last_gap    = 0;
    logic prev_req    = 1'b0;
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_req && !prev_req) begin
                    grant_cnt++;
                    last_gap = cyc - last_rv_cyc;
                    if (sb_en) begin
                        if (sb_q.size() == 0) begin
                            chk("grant_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                        end else begin
                            chk("grant_addr",  mem_addr,          sb_q[0].addr);
                            chk("grant_we",    32'(mem_we),       32'(sb_q[0].we));
                            chk("grant_re",    32'(mem_re),       32'(sb_q[0].re));
                            chk("grant_wdata", mem_wdata,         sb_q[0].wdata);
                        end
                    end
                end
                if (i_rvalid || d_rvalid) begin
                    last_rv_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        chk("rvalid_unexpected", {30'b0, i_rvalid, d_rvalid}, 32'h0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rv_port", {30'b0, i_rvalid, d_rvalid}, e.is_d ? 32'd1 : 32'd2);
                        chk("rv_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                    end
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_rv(input bit is_d);
        bit    got = 1'b0;
        string tag;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            got = is_d ? d_rvalid : i_rvalid;
        end
        tag = is_d ? "d_timeout" : "i_timeout";
        if (!got) chk(tag, 32'd0, 32'd1);
    endtask

    // fetch requester: req held across n transactions, new address after each rvalid
    task automatic fetch_seq(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            i_addr = base + 32'(4 * k);
            i_req  = 1'b1;
            wait_rv(1'b0);
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
    endtask

    task automatic data_seq(input int n, input logic [31:0] base, input logic [1:0] we,
                            input logic [2:0] re, input logic [31:0] wd);
        for (int k = 0; k < n; k++) begin
            d_addr  = base + 32'(4 * k);
            d_we    = we;
            d_re    = re;
            d_wdata = wd + 32'(k);
            d_req   = 1'b1;
            wait_rv(1'b1);
            @(posedge clk);
            #1;
        end
        d_req = 1'b0;
    endtask

    // latency probe: cycle of first mem_req, cycle of rvalid, stall cycles before it
    task automatic measure(input bit is_d, output int req_c, output int rv_c,
                           output int stall_n, output int stall_at_rv);
        req_c = -1; rv_c = -1; stall_n = 0; stall_at_rv = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_req && req_c < 0) req_c = c;
            if (is_d ? d_rvalid : i_rvalid) begin
                rv_c        = c;
                stall_at_rv = int'(is_d ? stall_m : stall_f);
                break;
            end
            if (is_d ? stall_m : stall_f) stall_n++;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int rq, rv, sn, rs, g0;
        logic [13:0] pat, pat_exp;

        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 2'b00; d_re = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; d_req = 1'b1;
        @(posedge clk); #1;
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_stall_f",  32'(stall_f),  32'd0);
        chk("rst_stall_m",  32'(stall_m),  32'd0);
        chk("rst_i_rdata",  i_rdata,       32'd0);
        chk("rst_d_rdata",  d_rdata,       32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        i_req = 1'b0; d_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // async reset in the middle of a data transaction
        sb_en = 1'b0; ack_k = 1000;
        d_addr = 32'h30; d_we = 2'b00; d_re = 3'b010; d_wdata = 32'h1234; d_req = 1'b1;
        @(posedge clk); #1;
        chk("t1_busy", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t1_mem_req",  32'(mem_req),  32'd0);
        chk("t1_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("t1_stall_m",  32'(stall_m),  32'd0);
        chk("t1_mem_addr", mem_addr,      32'd0);
        @(posedge clk); #1;
        d_req = 1'b0; rst = 1'b1; ack_always = 1'b1; sb_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t1_quiet", {29'b0, mem_req, i_rvalid, d_rvalid}, 32'd0);
        end
        @(posedge clk); #1;
        ack_always = 1'b0;

        // single fetch, ack two cycles after mem_req rises
        ack_k = 2;
        push_i(32'h10);
        fork
            fetch_seq(1, 32'h10);
            measure(1'b0, rq, rv, sn, rs);
        join
        chk("t2_req_cyc",   32'(rq), 32'd1);
        chk("t2_rv_cyc",    32'(rv), 32'd4);
        chk("t2_stall_cnt", 32'(sn), 32'd4);
        chk("t2_stall_rv",  32'(rs), 32'd0);
        @(negedge clk);
        chk("t2_rdata_hold", i_rdata, 32'h0050_0093);
        @(posedge clk); #1;

        // simultaneous requests: data first, then fetch two cycles after d_rvalid
        ack_k = 1;
        g0 = grant_cnt;
        push_d(32'h20, 2'b00, 3'b010, 32'h0);
        push_i(32'h40);
        fork
            fetch_seq(1, 32'h40);
            data_seq(1, 32'h20, 2'b00, 3'b010, 32'h0);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("t3_grants", 32'(grant_cnt - g0), 32'd2);
        chk("t3_gap",    32'(last_gap),       32'd2);

        // starvation bound with MAX_IWAIT=2: D, D, I, D, D, I
        ack_k = 0;
        push_d(32'h200, 2'b00, 3'b100, 32'h1000);
        push_d(32'h204, 2'b00, 3'b100, 32'h1001);
        push_i(32'h300);
        push_d(32'h208, 2'b00, 3'b100, 32'h1002);
        push_d(32'h20C, 2'b00, 3'b100, 32'h1003);
        push_i(32'h304);
        fork
            fetch_seq(2, 32'h300);
            data_seq(4, 32'h200, 2'b00, 3'b100, 32'h1000);
        join
        @(posedge clk); #1;
        chk("t4_sb_drained", 32'(sb_q.size()), 32'd0);

        // word store, ack in the first mem_req cycle
        ack_k = 0;
        push_d(32'h8, 2'b11, 3'b000, 32'hDEAD_BEEF);
        fork
            data_seq(1, 32'h8, 2'b11, 3'b000, 32'hDEAD_BEEF);
            measure(1'b1, rq, rv, sn, rs);
        join
        chk("t5_req_cyc",   32'(rq), 32'd1);
        chk("t5_rv_cyc",    32'(rv), 32'd2);
        chk("t5_stall_cnt", 32'(sn), 32'd2);
        chk("t5_stall_rv",  32'(rs), 32'd0);
        @(negedge clk);
        chk("t5_rdata_hold", d_rdata, mem_val(32'h8));
        @(posedge clk); #1;

        // ack held high, fetch held: one-cycle i_rvalid every 3 cycles
        ack_always = 1'b1;
        for (int k = 0; k < 4; k++) push_i(32'h100 + 32'(4 * k));
        pat = '0;
        pat_exp = '0;
        for (int c = 0; c < 14; c++) pat_exp[c] = (c % 3 == 2) && (c < 12);
        fork
            fetch_seq(4, 32'h100);
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                pat[c] = i_rvalid;
            end
        join
        chk("t6_rvalid_pattern", 32'(pat), 32'(pat_exp));
        ack_always = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
